filt_tx: RTL and testbench

Level-shaping serial transmitter, the sending end of the glitch-filtered single-wire link. It takes a parallel word over a valid/ready handshake and drives it onto one line as a framed bit sequence. Every symbol is held for exactly HOLD enabled cycles, so a downstream 4-state glitch filter (threshold: count > 9 enabled cycles) passes every symbol and rejects nothing. It sits on the clock-enable domain shared with the filters and freezes completely whenever `en` is low.

---
 rtl/filt_pkg.sv | 18 +
 rtl/filt_hold_cnt.sv | 47 ++++
 rtl/filt_tx.sv | 142 ++++++++++++++
 tb/tb_filt_tx.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/filt_pkg.sv
// filt_pkg: definitions shared by the glitch-filtered single-wire link.
// The transmitter and the receiver-side deglitcher both import it.
//   filt_tx_state_t : transmitter frame states
//   FILT_THRESH     : receiver filter passes a level held for this many enabled cycles
//   FILT_MIN_HOLD   : smallest legal symbol hold, the threshold plus a 2-cycle margin
package filt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } filt_tx_state_t;

    localparam int FILT_THRESH   = 10;
    localparam int FILT_MIN_HOLD = FILT_THRESH + 2;

endpackage

// File: rtl/filt_hold_cnt.sv
// filt_hold_cnt: enable-gated symbol timer that counts 0..HOLD-1 and wraps.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : clock enable; the count is frozen while low
//   clear      : forces the count to 0 on the next enabled edge (wins over run)
//   run        : counts on enabled edges while high
//   tc         : terminal count, high while the count equals HOLD-1
module filt_hold_cnt #(
    parameter int HOLD = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clear,
    input  logic run,
    output logic tc
);

    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tc = (count_q == CW'(HOLD - 1));

    // Wrap at HOLD-1 instead of rolling over the full binary range, so a
    // non-power-of-two HOLD still yields exactly HOLD cycles per period.
    always_comb begin
        count_d = count_q;
        if (en) begin
            if (clear) begin
                count_d = '0;
            end else if (run) begin
                count_d = tc ? '0 : count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/filt_tx.sv
// filt_tx: level-shaping serial transmitter for the glitch-filtered link.
// Sends start(1), WIDTH data bits LSB first, then stop(0), with every symbol
// held for HOLD enabled cycles, so the downstream filter never rejects one.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : clock enable shared with the filters; freezes everything
//   in_data    : word to send, captured on accept
//   in_valid   : word available
//   in_ready   : combinational, (state == IDLE) & en
//   y          : registered serial line, idles at 0
//   busy       : registered, high from accept until the end of the stop symbol
//   tx_done    : registered one-cycle pulse on the edge that leaves STOP
module filt_tx
    import filt_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int HOLD  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             y,
    output logic             busy,
    output logic             tx_done
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // A shorter hold would let the receiver filter eat legitimate symbols.
    if (HOLD < FILT_MIN_HOLD) begin : g_hold_check
        $error("filt_tx: HOLD must be at least FILT_MIN_HOLD");
    end

    filt_tx_state_t   state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             y_q, y_d;
    logic             busy_q, busy_d;
    logic             tx_done_q, tx_done_d;

    logic             accept;
    logic             hold_tc;
    logic [WIDTH-1:0] sr_shift;

    assign in_ready = (state_q == IDLE) & en;
    assign accept   = in_valid & in_ready;
    assign sr_shift = sr_q >> 1;

    assign y       = y_q;
    assign busy    = busy_q;
    assign tx_done = tx_done_q;

    // The symbol timer restarts on accept and otherwise runs through every
    // symbol, wrapping at HOLD-1 so each symbol boundary resets it for free.
    filt_hold_cnt #(
        .HOLD (HOLD)
    ) u_hold_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clear (accept),
        .run   (state_q != IDLE),
        .tc    (hold_tc)
    );

    // Next-state logic. tx_done defaults to 0 outside the enable so the
    // pulse clears on the following edge even while en is low.
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        y_d       = y_q;
        busy_d    = busy_q;
        tx_done_d = 1'b0;

        if (en) begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sr_d      = in_data;
                        y_d       = 1'b1;
                        state_d   = START;
                        bit_cnt_d = '0;
                        busy_d    = 1'b1;
                    end
                end
                START: begin
                    if (hold_tc) begin
                        state_d = DATA;
                        y_d     = sr_q[0];
                    end
                end
                DATA: begin
                    if (hold_tc) begin
                        if (bit_cnt_q == BW'(WIDTH - 1)) begin
                            state_d = STOP;
                            y_d     = 1'b0;
                        end else begin
                            sr_d      = sr_shift;
                            y_d       = sr_shift[0];
                            bit_cnt_d = bit_cnt_q + BW'(1);
                        end
                    end
                end
                STOP: begin
                    if (hold_tc) begin
                        state_d   = IDLE;
                        busy_d    = 1'b0;
                        tx_done_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    y_d     = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            y_q       <= 1'b0;
            busy_q    <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            y_q       <= y_d;
            busy_q    <= busy_d;
            tx_done_q <= tx_done_d;
        end
    end

endmodule

// File: tb/tb_filt_tx.sv
// tb_filt_tx: self-checking bench for filt_tx. A frame-level model predicts
// the line from the count of enabled edges since accept; directed scenarios
// are followed by randomized enable, valid and data.
module tb_filt_tx;

    localparam int WIDTH     = 8;
    localparam int HOLD      = 16;
    localparam int FRAME_LEN = (WIDTH + 2) * HOLD;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             y;
    logic             busy;
    logic             tx_done;

    int checkCount = 0;
    int errorCount = 0;

    // Reference model state: whether a frame is on the line, how many
    // enabled edges have elapsed counting the accept edge as 1, the word.
    bit               mActive = 1'b0;
    int               mK = 0;
    logic [WIDTH-1:0] mWord = '0;
    bit               mDone = 1'b0;
    int               doneCount = 0;

    always #5 clk = ~clk;

    filt_tx #(
        .WIDTH (WIDTH),
        .HOLD  (HOLD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .y        (y),
        .busy     (busy),
        .tx_done  (tx_done)
    );

    // Compare one observed value against the model and tally the result.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Symbol sequence of a frame: start 1, data LSB first, stop 0.
    function automatic logic expectedLine();
        int sym;
        if (!mActive) return 1'b0;
        sym = (mK - 1) / HOLD;
        if (sym == 0) return 1'b1;
        if (sym <= WIDTH) return mWord[sym - 1];
        return 1'b0;
    endfunction

    // Drive one clock cycle of inputs, advance the model across the edge,
    // then compare the registered outputs just after the edge.
    task automatic applyStimulus(input bit enV, input bit validV, input logic [WIDTH-1:0] dataV);
        en       = enV;
        in_valid = validV;
        in_data  = dataV;
        #1;
        checkOutput("in_ready", in_ready, (!mActive && enV));
        @(posedge clk);
        mDone = 1'b0;
        if (enV) begin
            if (!mActive) begin
                if (validV) begin
                    mActive = 1'b1;
                    mK      = 1;
                    mWord   = dataV;
                end
            end else begin
                mK++;
                if (mK > FRAME_LEN) begin
                    mActive = 1'b0;
                    mDone   = 1'b1;
                    doneCount++;
                end
            end
        end
        #1;
        checkOutput("y", y, expectedLine());
        checkOutput("busy", busy, mActive);
        checkOutput("tx_done", tx_done, mDone);
    endtask

    // Assert reset away from the clock edge; outputs must drop at once.
    task automatic applyReset();
        en       = 1'b0;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_y", y, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_tx_done", tx_done, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mActive = 1'b0;
        mK      = 0;
        mDone   = 1'b0;
    endtask

    initial begin
        int n;
        int doneAt;
        int startDone;

        $display("[TB] starting filt_tx bench");
        applyReset();

        // Idle with enable high and nothing offered.
        for (int c = 0; c < 50; c++) applyStimulus(1'b1, 1'b0, '0);

        // Single 0xA5 frame at full enable; tx_done must come 160 edges after accept.
        applyStimulus(1'b1, 1'b1, 8'hA5);
        n = 0;
        doneAt = -1;
        for (int c = 0; c < 400 && doneAt < 0; c++) begin
            applyStimulus(1'b1, 1'b0, 8'h00);
            n++;
            if (tx_done === 1'b1) doneAt = n;
        end
        checkOutput("a5_frame_len", doneAt, FRAME_LEN);
        for (int c = 0; c < 5; c++) applyStimulus(1'b1, 1'b0, '0);

        // Enable toggling every cycle doubles the wall-clock symbol length.
        applyStimulus(1'b1, 1'b1, 8'hA5);
        n = 0;
        doneAt = -1;
        for (int c = 0; c < 800 && doneAt < 0; c++) begin
            applyStimulus(c[0] ? 1'b1 : 1'b0, 1'b0, 8'h00);
            n++;
            if (tx_done === 1'b1) doneAt = n;
        end
        checkOutput("toggle_frame_len", doneAt, 2 * FRAME_LEN);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("tx_done_cleared_en_low", tx_done, 1'b0);

        // Back-to-back with valid held: 0x00 then 0xFF.
        startDone = doneCount;
        applyStimulus(1'b1, 1'b1, 8'h00);
        for (int c = 0; c < 1000 && doneCount < startDone + 2; c++) begin
            applyStimulus(1'b1, 1'b1, (doneCount > startDone) ? 8'hFF : 8'h00);
        end
        checkOutput("b2b_frames", doneCount - startDone, 2);
        for (int c = 0; c < 5; c++) applyStimulus(1'b1, 1'b0, '0);

        // Reset during data bit 3, then a clean frame.
        applyStimulus(1'b1, 1'b1, 8'hC3);
        for (int c = 0; c < 400 && mK < 4 * HOLD + 6; c++) applyStimulus(1'b1, 1'b0, '0);
        checkOutput("mid_frame_pos", mK, 4 * HOLD + 6);
        applyReset();
        applyStimulus(1'b1, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 8'h3C);
        for (int c = 0; c < 400 && mActive; c++) applyStimulus(1'b1, 1'b0, '0);

        // Randomized enable, valid and data.
        startDone = doneCount;
        for (int c = 0; c < 6000; c++) begin
            applyStimulus(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                          WIDTH'($urandom));
        end
        checkOutput("random_frames_seen", (doneCount - startDone) > 10, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
